seq_shifter: RTL and testbench

Multi-cycle, parametrised shift unit for the ALU datapath. It replaces the fixed single-position shifter with a shift by a programmable amount, moving one position per clock. It supports four modes (arithmetic right, logical left, logical right, rotate left) and uses a start/ready/done handshake. The ALU controller issues one operation at a time and samples the result on done.

---
 rtl/seq_shifter.sv | 156 +++++++++++++++
 tb/tb_seq_shifter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/seq_shifter.sv
// -----------------------------------------------------------------------------
// seq_shifter
//   Multi-cycle shift unit for the ALU datapath. The operand is shifted by a
//   programmable amount, one bit position per clock. It supports four modes:
//   arithmetic right, logical left, logical right and rotate left.
//   Operations are issued with a start/ready/done handshake.
//
// Optional feature macro: SEQ_SHIFTER_FLAGS_EN
//   When defined, the block adds the cout and zero flag outputs.
//
// Parameters
//   WIDTH    data width in bits (minimum 2)
//   SHAMT_W  shift-amount width; the largest amount is 2^SHAMT_W-1
//
// Ports
//   clk    rising-edge system clock
//   rst    asynchronous active-high reset
//   start  operation request, accepted only while ready=1
//   op     00 arith right, 01 logical left, 10 logical right, 11 rotate left
//   amt    unsigned shift amount
//   in     operand
//   ready  high in IDLE only
//   busy   complement of ready
//   done   one-cycle pulse when out holds the final result
//   out    result register
//   cout   (flags build) last bit shifted or rotated out
//   zero   (flags build) registered out==0 of the finished result
// -----------------------------------------------------------------------------
module seq_shifter #(
    parameter int WIDTH   = 17,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [SHAMT_W-1:0] amt,
    input  logic [WIDTH-1:0]   in,
    output logic               ready,
    output logic               busy,
    output logic               done,
    output logic [WIDTH-1:0]   out
`ifdef SEQ_SHIFTER_FLAGS_EN
    ,
    output logic               cout,
    output logic               zero
`endif
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [1:0] OP_SRA = 2'b00;
    localparam logic [1:0] OP_SLL = 2'b01;
    localparam logic [1:0] OP_SRL = 2'b10;
    localparam logic [1:0] OP_ROL = 2'b11;

    logic [1:0]         state;
    logic [1:0]         op_q;
    logic [SHAMT_W-1:0] count;

    // Single-position step for the given mode.
    function automatic logic [WIDTH-1:0] shift_step(input logic [1:0] mode,
                                                    input logic [WIDTH-1:0] v);
        logic [WIDTH-1:0] r;
        case (mode)
            OP_SRA:  r = {v[WIDTH-1], v[WIDTH-1:1]};
            OP_SLL:  r = {v[WIDTH-2:0], 1'b0};
            OP_SRL:  r = {1'b0, v[WIDTH-1:1]};
            default: r = {v[WIDTH-2:0], v[WIDTH-1]};
        endcase
        return r;
    endfunction

    // The bit that leaves the word on a single step: MSB for left and rotate
    // shifts, LSB for right shifts.
    function automatic logic step_out_bit(input logic [1:0] mode,
                                          input logic [WIDTH-1:0] v);
        return (mode == OP_SLL || mode == OP_ROL) ? v[WIDTH-1] : v[0];
    endfunction

    assign ready = (state == ST_IDLE);
    assign busy  = ~ready;
    assign done  = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            op_q  <= 2'b00;
            count <= '0;
            out   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        out  <= in;
                        op_q <= op;
                        if (amt == '0) begin
                            state <= ST_DONE;
                        end else begin
                            count <= amt;
                            state <= ST_SHIFT;
                        end
                    end
                end
                ST_SHIFT: begin
                    out   <= shift_step(op_q, out);
                    count <= count - 1'b1;
                    // count==1 means this edge performs the last step.
                    if (count == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef SEQ_SHIFTER_FLAGS_EN
    // zero is computed on the edge that enters DONE so it is already valid
    // while done is high; cout tracks every executed step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cout <= 1'b0;
            zero <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (amt == '0) begin
                            zero <= (in == '0);
                        end else begin
                            cout <= 1'b0;
                        end
                    end
                end
                ST_SHIFT: begin
                    cout <= step_out_bit(op_q, out);
                    if (count == {{(SHAMT_W-1){1'b0}}, 1'b1}) begin
                        zero <= (shift_step(op_q, out) == '0);
                    end
                end
                default: begin
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_seq_shifter.sv
// -----------------------------------------------------------------------------
// tb_seq_shifter
//   Scoreboard bench for seq_shifter (default parameters, WIDTH=17).
//   The driver pushes hand-computed expectations when it issues an operation.
//   The monitor pops and compares one entry every time done is seen.
// -----------------------------------------------------------------------------
module tb_seq_shifter;

    logic        clk;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [4:0]  amt;
    logic [16:0] in_d;
    logic        ready;
    logic        busy;
    logic        done;
    logic [16:0] out;
`ifdef SEQ_SHIFTER_FLAGS_EN
    logic        cout;
    logic        zero;
`endif

    seq_shifter #(.WIDTH(17), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .op    (op),
        .amt   (amt),
        .in    (in_d),
        .ready (ready),
        .busy  (busy),
        .done  (done),
        .out   (out)
`ifdef SEQ_SHIFTER_FLAGS_EN
        ,
        .cout  (cout),
        .zero  (zero)
`endif
    );

    typedef struct {
        logic [16:0] out;
        int          lat;
        logic        cout;
        logic        zero;
        int          acc;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: protocol invariants every cycle, plus the scoreboard pop on done.
    always @(negedge clk) begin
        exp_t e;
        check("busy_is_not_ready", {31'd0, busy}, {31'd0, ~ready});
        check("done_and_ready_exclusive", {31'd0, done & ready}, 32'd0);
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                n_assert++;
                n_fail++;
                $display("FAIL unexpected_done: got done=1 expected no pending operation");
            end else begin
                e = sb.pop_front();
                check({e.name, "_out"}, {15'd0, out}, {15'd0, e.out});
                check({e.name, "_latency"}, cyc - e.acc + 1, e.lat);
`ifdef SEQ_SHIFTER_FLAGS_EN
                check({e.name, "_cout"}, {31'd0, cout}, {31'd0, e.cout});
                check({e.name, "_zero"}, {31'd0, zero}, {31'd0, e.zero});
`endif
            end
        end
    end

    task automatic issue(input string name, input logic [1:0] o, input logic [4:0] a,
                         input logic [16:0] d, input logic [16:0] eo, input int el,
                         input logic ec, input logic ez, input bit push);
        exp_t e;
        int   t;
        t = 0;
        @(negedge clk);
        while (ready !== 1'b1 && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (ready !== 1'b1) begin
            n_assert++;
            n_fail++;
            $display("FAIL %s_ready_timeout: got ready=%b expected 1", name, ready);
            return;
        end
        op    = o;
        amt   = a;
        in_d  = d;
        start = 1'b1;
        if (push) begin
            e.out  = eo;
            e.lat  = el;
            e.cout = ec;
            e.zero = ez;
            e.acc  = cyc + 1;
            e.name = name;
            sb.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int t;
        rst   = 1'b0;
        start = 1'b0;
        op    = 2'b00;
        amt   = 5'd0;
        in_d  = 17'd0;
        #2 rst = 1'b1;
        #1;
        check("rst_out", {15'd0, out}, 32'd0);
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
`ifdef SEQ_SHIFTER_FLAGS_EN
        check("rst_cout", {31'd0, cout}, 32'd0);
        check("rst_zero", {31'd0, zero}, 32'd0);
`endif
        repeat (2) @(negedge clk);
        rst = 1'b0;

        //      name         op     amt    in          out         lat cout zero
        issue("sra1",      2'b00, 5'd1,  17'h1FF01, 17'h1FF80, 2,  1'b1, 1'b0, 1'b1);
        issue("sll1",      2'b01, 5'd1,  17'h0FF01, 17'h1FE02, 2,  1'b0, 1'b0, 1'b1);
        issue("srl16",     2'b10, 5'd16, 17'h10000, 17'h00001, 17, 1'b0, 1'b0, 1'b1);
        issue("amt0",      2'b01, 5'd0,  17'h0ABCD, 17'h0ABCD, 1,  1'b0, 1'b0, 1'b1);
        issue("rol1",      2'b11, 5'd1,  17'h10001, 17'h00003, 2,  1'b1, 1'b0, 1'b1);
        issue("rol18",     2'b11, 5'd18, 17'h10001, 17'h00003, 19, 1'b1, 1'b0, 1'b1);
        issue("sra31_sat", 2'b00, 5'd31, 17'h10000, 17'h1FFFF, 32, 1'b1, 1'b0, 1'b1);
        issue("srl31_sat", 2'b10, 5'd31, 17'h10000, 17'h00000, 32, 1'b0, 1'b1, 1'b1);

        // start pulsed with junk operands while the shift is running
        issue("sll5_busy", 2'b01, 5'd5,  17'h00003, 17'h00060, 6,  1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            op    = 2'b11;
            amt   = 5'd7;
            in_d  = 17'h1AAAA;
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end

        // reset in the middle of a long shift: no done may follow
        issue("abort", 2'b00, 5'd10, 17'h12345, 17'h00000, 0, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("abort_out", {15'd0, out}, 32'd0);
        check("abort_ready", {31'd0, ready}, 32'd1);
        check("abort_done", {31'd0, done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);

        issue("srl2_after_rst", 2'b10, 5'd2, 17'h00010, 17'h00004, 3, 1'b0, 1'b0, 1'b1);

        t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        repeat (4) @(negedge clk);
        check("scoreboard_drained", sb.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
